// File: rtl/mem_a_addresses_generator.sv
// rtl/mem_a_addresses_generator.sv - A-matrix read address sequencer feeding the systolic array A buffer
module mem_a_addresses_generator #(
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ARRAY_HEIGHT     = 4,
    parameter int ARRAY_WIDTH      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] m,
    input  logic [15:0] n,
    input  logic [15:0] p,
    input  logic [15:0] base_addr_a,
    output logic        do_tran,
    output logic [15:0] addr,
    input  logic        tran_done,
    input  logic        fifo_full,
    output logic        fifo_push,
    output logic        op_done
);

    localparam logic [1:0] IDL         = 2'd0;
    localparam logic [1:0] WAIT_SPACE  = 2'd1;
    localparam logic [1:0] READ_DATA   = 2'd2;
    localparam logic [1:0] UPDATE_ADDR = 2'd3;

    localparam int          SHIFT    = $clog2(DATA_WIDTH_BYTES);
    localparam logic [16:0] COL_STEP = 17'(BUS_WIDTH_BYTES / DATA_WIDTH_BYTES);
    localparam logic [16:0] HEIGHT   = 17'(ARRAY_HEIGHT);
    localparam logic [16:0] WIDTH    = 17'(ARRAY_WIDTH);

    logic [1:0]  state;
    logic [15:0] m_q, n_q, p_q, base_q;
    logic [15:0] row, k, cb, rm;
    logic        zero_done;

    logic        row_wrap, k_wrap, cb_wrap, rm_wrap, last, dims_ok;
    logic [15:0] row_idx, elem;
    logic [31:0] prod;

    // Wrap tests use >= in 17 bits so out-of-range dimensions still terminate
    assign row_wrap = ({1'b0, row} + 17'd1)    >= HEIGHT;
    assign k_wrap   = ({1'b0, k}   + COL_STEP) >= {1'b0, n_q};
    assign cb_wrap  = ({1'b0, cb}  + WIDTH)    >= {1'b0, p_q};
    assign rm_wrap  = ({1'b0, rm}  + HEIGHT)   >= {1'b0, m_q};
    assign last     = row_wrap & k_wrap & cb_wrap & rm_wrap;
    assign dims_ok  = (m != 16'd0) && (n != 16'd0) && (p != 16'd0);

    // Counters only move in UPDATE_ADDR, so addr is stable across WAIT_SPACE/READ_DATA
    assign row_idx = rm + row;
    assign prod    = 32'(row_idx) * 32'(n_q);
    assign elem    = base_q + prod[15:0] + k;
    assign addr    = elem << SHIFT;

    assign fifo_push = (state == UPDATE_ADDR);
    assign op_done   = zero_done | (last & (state == UPDATE_ADDR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDL;
            do_tran   <= 1'b0;
            zero_done <= 1'b0;
            m_q       <= '0;
            n_q       <= '0;
            p_q       <= '0;
            base_q    <= '0;
            row       <= '0;
            k         <= '0;
            cb        <= '0;
            rm        <= '0;
        end else begin
            zero_done <= 1'b0;

            if (tran_done)
                do_tran <= 1'b0;
            else if (state == READ_DATA)
                do_tran <= 1'b1;

            case (state)
                IDL: begin
                    if (start_i) begin
                        m_q    <= m;
                        n_q    <= n;
                        p_q    <= p;
                        base_q <= base_addr_a;
                        row    <= '0;
                        k      <= '0;
                        cb     <= '0;
                        rm     <= '0;
                        if (dims_ok)
                            state <= WAIT_SPACE;
                        else
                            zero_done <= 1'b1;
                    end
                end
                WAIT_SPACE: begin
                    if (!fifo_full)
                        state <= READ_DATA;
                end
                READ_DATA: begin
                    if (tran_done)
                        state <= UPDATE_ADDR;
                end
                UPDATE_ADDR: begin
                    state <= last ? IDL : WAIT_SPACE;
                    // A row block is re-read for every cb so each C column tile gets its operands
                    if (row_wrap) begin
                        row <= '0;
                        if (k_wrap) begin
                            k <= '0;
                            if (cb_wrap) begin
                                cb <= '0;
                                if (rm_wrap)
                                    rm <= '0;
                                else
                                    rm <= rm + 16'(ARRAY_HEIGHT);
                            end else begin
                                cb <= cb + 16'(ARRAY_WIDTH);
                            end
                        end else begin
                            k <= k + COL_STEP[15:0];
                        end
                    end else begin
                        row <= row + 16'd1;
                    end
                end
                default: state <= IDL;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_a_addresses_generator.sv
// tb/tb_mem_a_addresses_generator.sv - directed self-checking bench for mem_a_addresses_generator
module tb_mem_a_addresses_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] m = '0, n = '0, p = '0, base_addr_a = '0;
    logic        do_tran;
    logic [15:0] addr;
    logic        tran_done = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_push;
    logic        op_done;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int push_cnt = 0;
    logic [15:0] exp_q[$];

    mem_a_addresses_generator dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .m           (m),
        .n           (n),
        .p           (p),
        .base_addr_a (base_addr_a),
        .do_tran     (do_tran),
        .addr        (addr),
        .tran_done   (tran_done),
        .fifo_full   (fifo_full),
        .fifo_push   (fifo_push),
        .op_done     (op_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (op_done === 1'b1) done_cnt <= done_cnt + 1;
        if (fifo_push === 1'b1) push_cnt <= push_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_op(input logic [15:0] mm, input logic [15:0] nn,
                            input logic [15:0] pp, input logic [15:0] bb);
        m = mm; n = nn; p = pp; base_addr_a = bb;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        m = 16'h0008; n = 16'h0030; p = 16'h0060; base_addr_a = 16'h1234;
    endtask

    // Services reads 0..limit-1 of exp_q; tran_done comes 2 cycles after do_tran is seen
    task automatic service(input int limit, input bit poke);
        int nrd;
        nrd = exp_q.size();
        for (int i = 0; i < limit; i++) begin
            int t;
            t = 0;
            while (do_tran !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("do_tran_timeout", 32'(t < 100), 32'd1);
            chk("addr", 32'(addr), 32'(exp_q[i]));
            repeat (2) @(negedge clk);
            chk("addr_stable", 32'(addr), 32'(exp_q[i]));
            tran_done = 1'b1;
            if (poke && i == 1) begin
                start_i = 1'b1;
                m = 16'd4; n = 16'd0; p = 16'd32;
            end
            @(negedge clk);
            tran_done = 1'b0;
            start_i = 1'b0;
            chk("fifo_push", 32'(fifo_push), 32'd1);
            chk("op_done", 32'(op_done), 32'(i == nrd - 1));
        end
    endtask

    task automatic load_basic(input logic [15:0] base_lo);
        exp_q.delete();
        exp_q.push_back(base_lo);
        exp_q.push_back(base_lo + 16'h0020);
        exp_q.push_back(base_lo + 16'h0040);
        exp_q.push_back(base_lo + 16'h0060);
    endtask

    initial begin
        int d0, p0;
        bit bad;

        repeat (2) @(negedge clk);
        chk("rst_do_tran", 32'(do_tran), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_fifo_push", 32'(fifo_push), 32'd0);
        chk("rst_op_done", 32'(op_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic single tile, with a stray start mid-operation
        load_basic(16'h0000);
        d0 = done_cnt; p0 = push_cnt;
        start_op(16'd4, 16'd16, 16'd32, 16'h0000);
        service(4, 1'b1);
        repeat (3) @(negedge clk);
        chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("basic_push_cnt", 32'(push_cnt - p0), 32'd4);
        chk("basic_idle_do_tran", 32'(do_tran), 32'd0);

        // two k steps, two cb tiles
        exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(16'h0000); exp_q.push_back(16'h0040);
            exp_q.push_back(16'h0080); exp_q.push_back(16'h00C0);
            exp_q.push_back(16'h0020); exp_q.push_back(16'h0060);
            exp_q.push_back(16'h00A0); exp_q.push_back(16'h00E0);
        end
        d0 = done_cnt; p0 = push_cnt;
        start_op(16'd4, 16'd32, 16'd64, 16'h0000);
        service(16, 1'b0);
        repeat (3) @(negedge clk);
        chk("multi_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("multi_push_cnt", 32'(push_cnt - p0), 32'd16);

        // 16-bit address wrap
        exp_q.delete();
        exp_q.push_back(16'hFFE0); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0020); exp_q.push_back(16'h0040);
        start_op(16'd4, 16'd16, 16'd32, 16'hFFF0);
        service(4, 1'b0);
        repeat (2) @(negedge clk);

        // back-pressure before the first read
        load_basic(16'h0000);
        fifo_full = 1'b1;
        start_op(16'd4, 16'd16, 16'd32, 16'h0000);
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (do_tran !== 1'b0) bad = 1'b1;
            if (c < 9) @(negedge clk);
        end
        chk("full_no_do_tran", 32'(bad), 32'd0);
        chk("full_state_wait", 32'(dut.state), 32'd1);
        fifo_full = 1'b0;
        @(negedge clk);
        chk("full_release_state", 32'(dut.state), 32'd2);
        chk("full_release_do_tran0", 32'(do_tran), 32'd0);
        @(negedge clk);
        chk("full_release_do_tran1", 32'(do_tran), 32'd1);
        service(4, 1'b0);
        repeat (2) @(negedge clk);

        // reset mid-operation, then restart
        d0 = done_cnt;
        start_op(16'd4, 16'd16, 16'd32, 16'h0000);
        service(2, 1'b0);
        reset = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (do_tran !== 1'b0 || addr !== 16'h0000 || fifo_push !== 1'b0 || op_done !== 1'b0)
                bad = 1'b1;
        end
        chk("mid_reset_outputs", 32'(bad), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_no_done", 32'(done_cnt - d0), 32'd0);
        start_op(16'd4, 16'd16, 16'd32, 16'h0000);
        service(4, 1'b0);
        repeat (2) @(negedge clk);

        // zero dimension start
        d0 = done_cnt; p0 = push_cnt;
        start_op(16'd4, 16'd0, 16'd32, 16'h0000);
        chk("zero_op_done", 32'(op_done), 32'd1);
        @(negedge clk);
        chk("zero_op_done_pulse", 32'(op_done), 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (do_tran !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("zero_no_do_tran", 32'(bad), 32'd0);
        chk("zero_no_push", 32'(push_cnt - p0), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
